// File: rtl/ycbcr_frame_sequencer.sv
// Frame sequencer around a free-running RGB->YCbCr converter.
// Counts pixels, tracks converter latency, buffers tagged results.
module ycbcr_frame_sequencer #(
  parameter int DATA_W    = 8,
  parameter int CONV_LAT  = 1,
  parameter int OUT_DEPTH = 4,
  parameter int COL_W     = 10,
  parameter int ROW_W     = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [COL_W-1:0]  frame_w,
  input  logic [ROW_W-1:0]  frame_h,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [23:0]       in_rgb,
  output logic [7:0]        conv_red,
  output logic [7:0]        conv_green,
  output logic [7:0]        conv_blue,
  input  logic [DATA_W-1:0] conv_luma,
  input  logic [DATA_W-1:0] conv_cb,
  input  logic [DATA_W-1:0] conv_cr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_y,
  output logic [DATA_W-1:0] out_cb,
  output logic [DATA_W-1:0] out_cr,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof
);

  localparam int PIPE_N = CONV_LAT + 1;
  localparam int PTR_W  = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
  localparam int CNT_W  = $clog2(OUT_DEPTH + PIPE_N + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] y;
    logic [DATA_W-1:0] cb;
    logic [DATA_W-1:0] cr;
    logic              sof;
    logic              eol;
    logic              eof;
  } ent_t;

  state_e           state_q;
  logic [COL_W-1:0] w_q, col_q;
  logic [ROW_W-1:0] h_q, row_q;
  logic             done_q;
  logic [7:0]       red_q, green_q, blue_q;

  logic [PIPE_N-1:0] pv_q;
  logic [2:0]        ptag_q [PIPE_N];
  ent_t              mem_q [OUT_DEPTH];
  logic [PTR_W-1:0]  wr_q, rd_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  inflight;

  logic accept, push, pop;
  logic last_col, last_row;
  logic [2:0] tag_in;
  ent_t head;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < PIPE_N; i++)
      inflight = inflight + CNT_W'(pv_q[i]);
  end

  // Credit covers both buffered and in-flight pixels.
  assign in_ready = (state_q == S_RUN) &&
                    ((cnt_q + inflight) < CNT_W'(OUT_DEPTH));
  assign accept   = in_valid & in_ready;
  assign push     = pv_q[PIPE_N-1];
  assign pop      = out_valid & out_ready;

  assign last_col = (col_q == w_q - COL_W'(1));
  assign last_row = (row_q == h_q - ROW_W'(1));
  assign tag_in   = {(col_q == '0) && (row_q == '0),
                     last_col, last_col & last_row};

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + CNT_W'(1);
    else if (pop && !push)
      cnt_d = cnt_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      w_q     <= '0;
      h_q     <= '0;
      col_q   <= '0;
      row_q   <= '0;
      done_q  <= 1'b0;
      red_q   <= '0;
      green_q <= '0;
      blue_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort) begin
        state_q <= S_IDLE;
      end else begin
        unique case (state_q)
          S_IDLE: begin
            if (start) begin
              if (frame_w != '0 && frame_h != '0) begin
                w_q     <= frame_w;
                h_q     <= frame_h;
                col_q   <= '0;
                row_q   <= '0;
                state_q <= S_RUN;
              end else begin
                done_q <= 1'b1;
              end
            end
          end
          S_RUN: begin
            if (accept) begin
              red_q   <= in_rgb[23:16];
              green_q <= in_rgb[15:8];
              blue_q  <= in_rgb[7:0];
              if (last_col) begin
                col_q <= '0;
                row_q <= row_q + ROW_W'(1);
                if (last_row)
                  state_q <= S_DRAIN;
              end else begin
                col_q <= col_q + COL_W'(1);
              end
            end
          end
          S_DRAIN: begin
            if (pv_q == '0 && cnt_q == '0) begin
              state_q <= S_IDLE;
              done_q  <= 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pv_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < PIPE_N; i++)
        ptag_q[i] <= '0;
    end else if (abort) begin
      pv_q  <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      pv_q[0]   <= accept;
      ptag_q[0] <= tag_in;
      for (int i = 1; i < PIPE_N; i++) begin
        pv_q[i]   <= pv_q[i-1];
        ptag_q[i] <= ptag_q[i-1];
      end
      if (push)
        wr_q <= (wr_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : wr_q + PTR_W'(1);
      if (pop)
        rd_q <= (rd_q == PTR_W'(OUT_DEPTH - 1)) ? '0 : rd_q + PTR_W'(1);
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_q] <= {conv_luma, conv_cb, conv_cr, ptag_q[PIPE_N-1]};
  end

  assign head       = mem_q[rd_q];
  assign busy       = (state_q != S_IDLE);
  assign done       = done_q;
  assign conv_red   = red_q;
  assign conv_green = green_q;
  assign conv_blue  = blue_q;
  assign out_valid  = (cnt_q != '0);
  assign out_y      = out_valid ? head.y   : '0;
  assign out_cb     = out_valid ? head.cb  : '0;
  assign out_cr     = out_valid ? head.cr  : '0;
  assign out_sof    = out_valid & head.sof;
  assign out_eol    = out_valid & head.eol;
  assign out_eof    = out_valid & head.eof;

endmodule

// File: tb/tb_ycbcr_frame_sequencer.sv
// Bench for ycbcr_frame_sequencer: stub converter (Y=R, Cb=G, Cr=B)
// and a queue-based frame model.
module tb_ycbcr_frame_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, abort;
  logic [9:0]  frame_w, frame_h;
  logic        busy, done;
  logic        in_valid, in_ready;
  logic [23:0] in_rgb;
  logic [7:0]  conv_red, conv_green, conv_blue;
  logic [7:0]  conv_luma, conv_cb, conv_cr;
  logic        out_valid, out_ready;
  logic [7:0]  out_y, out_cb, out_cr;
  logic        out_sof, out_eol, out_eof;

  ycbcr_frame_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .abort      (abort),
    .frame_w    (frame_w),
    .frame_h    (frame_h),
    .busy       (busy),
    .done       (done),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rgb     (in_rgb),
    .conv_red   (conv_red),
    .conv_green (conv_green),
    .conv_blue  (conv_blue),
    .conv_luma  (conv_luma),
    .conv_cb    (conv_cb),
    .conv_cr    (conv_cr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_y      (out_y),
    .out_cb     (out_cb),
    .out_cr     (out_cr),
    .out_sof    (out_sof),
    .out_eol    (out_eol),
    .out_eof    (out_eof)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    {conv_luma, conv_cb, conv_cr} <= {conv_red, conv_green, conv_blue};

  int n_cmp = 0;
  int n_err = 0;
  int n_acc, n_pop, done_seen;
  int mw, mh;
  logic [26:0] exp_q[$];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic do_cycle(input bit iv, input bit orr,
                          input logic [23:0] rgb);
    logic acc, pp;
    logic [26:0] got, e;
    bit sof, eol, eof;
    in_valid  = iv;
    out_ready = orr;
    in_rgb    = rgb;
    #4;
    acc = in_valid & in_ready;
    pp  = out_valid & out_ready;
    got = {out_y, out_cb, out_cr, out_sof, out_eol, out_eof};
    if (done) done_seen++;
    if (abort) begin
      exp_q.delete();
    end else begin
      if (pp) begin
        if (exp_q.size() == 0) begin
          chk("spurious_out", 32'(got), 32'h0);
        end else begin
          e = exp_q.pop_front();
          chk("out_pixel", 32'(got), 32'(e));
        end
        n_pop++;
      end
      if (acc) begin
        if (mw == 0 || n_acc >= mw * mh) begin
          chk("extra_accept", 32'(n_acc), 32'(mw * mh));
        end else begin
          sof = (n_acc == 0);
          eol = ((n_acc % mw) == mw - 1);
          eof = (n_acc == mw * mh - 1);
          exp_q.push_back({rgb, sof, eol, eof});
          chk("credit", 32'(exp_q.size() <= 4), 32'h1);
        end
        n_acc++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input int w, input int h);
    n_acc = 0;
    n_pop = 0;
    done_seen = 0;
    mw = (w != 0 && h != 0) ? w : 0;
    mh = h;
    frame_w = 10'(w);
    frame_h = 10'(h);
    start = 1'b1;
    do_cycle(1'b0, 1'b1, 24'h0);
    start = 1'b0;
  endtask

  task automatic run_until_done(input int pv, input int pr);
    for (int i = 0; i < 2000 && done_seen == 0; i++)
      do_cycle($urandom_range(99) < pv, $urandom_range(99) < pr,
               24'($urandom));
    for (int i = 0; i < 3; i++)
      do_cycle(1'b0, 1'b1, 24'h0);
    chk("done_once", 32'(done_seen), 32'd1);
    chk("busy_after", 32'(busy), 32'h0);
    chk("model_empty", 32'(exp_q.size()), 32'h0);
    chk("accepted", 32'(n_acc), 32'(mw * mh));
    chk("delivered", 32'(n_pop), 32'(mw * mh));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    frame_w = '0;
    frame_h = '0;
    in_valid = 1'b0;
    in_ready_dummy();
    out_ready = 1'b0;
    in_rgb = '0;
    mw = 0; mh = 0; n_acc = 0; n_pop = 0; done_seen = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_conv", 32'({conv_red, conv_green, conv_blue}), 32'h0);
    chk("rst_out", 32'({out_y, out_cb, out_cr, out_sof, out_eol, out_eof}),
        32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    start_frame(4, 2);
    run_until_done(100, 100);

    start_frame(4, 2);
    for (int i = 0; i < 20; i++)
      do_cycle(1'b1, 1'b0, 24'($urandom));
    chk("bp_accepts", 32'(n_acc), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    chk("bp_out_valid", 32'(out_valid), 32'h1);
    run_until_done(100, 100);

    start_frame(1, 1);
    do_cycle(1'b1, 1'b0, 24'hFF0000);
    chk("lat_conv_red", 32'(conv_red), 32'hFF);
    chk("lat_e0_valid", 32'(out_valid), 32'h0);
    do_cycle(1'b0, 1'b0, 24'h0);
    chk("lat_e1_valid", 32'(out_valid), 32'h0);
    do_cycle(1'b0, 1'b0, 24'h0);
    chk("lat_e2_valid", 32'(out_valid), 32'h1);
    chk("lat_e2_y", 32'(out_y), 32'hFF);
    chk("lat_e2_cbcr", 32'({out_cb, out_cr}), 32'h0);
    chk("lat_e2_tags", 32'({out_sof, out_eol, out_eof}), 32'h7);
    run_until_done(100, 100);

    for (int f = 0; f < 6; f++) begin
      start_frame($urandom_range(6, 1), $urandom_range(4, 1));
      run_until_done($urandom_range(90, 30), $urandom_range(90, 30));
    end

    start_frame(0, 3);
    chk("zero_done", 32'(done), 32'h1);
    chk("zero_busy", 32'(busy), 32'h0);
    do_cycle(1'b1, 1'b1, 24'h123456);
    chk("zero_done_end", 32'(done), 32'h0);
    chk("zero_busy2", 32'(busy), 32'h0);
    chk("zero_accepts", 32'(n_acc), 32'h0);

    start_frame(4, 2);
    for (int i = 0; i < 50 && n_acc < 3; i++)
      do_cycle(1'b1, 1'b0, 24'($urandom));
    chk("abort_pre_acc", 32'(n_acc), 32'd3);
    done_seen = 0;
    abort = 1'b1;
    do_cycle(1'b1, 1'b0, 24'($urandom));
    abort = 1'b0;
    chk("abort_out_valid", 32'(out_valid), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);
    for (int i = 0; i < 4; i++)
      do_cycle(1'b1, 1'b1, 24'($urandom));
    chk("abort_no_done", 32'(done_seen), 32'h0);
    chk("abort_out_valid2", 32'(out_valid), 32'h0);
    start_frame(4, 2);
    run_until_done(100, 100);

    start_frame(2, 2);
    for (int i = 0; i < 8; i++)
      do_cycle(1'b1, 1'b0, 24'($urandom));
    chk("drain_busy", 32'(busy), 32'h1);
    chk("drain_out_valid", 32'(out_valid), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'h0);
    chk("arst_out_valid", 32'(out_valid), 32'h0);
    chk("arst_out", 32'({out_y, out_cb, out_cr, out_sof, out_eol, out_eof}),
        32'h0);
    chk("arst_conv", 32'({conv_red, conv_green, conv_blue}), 32'h0);
    chk("arst_in_ready", 32'(in_ready), 32'h0);
    exp_q.delete();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    start_frame(4, 2);
    for (int i = 0; i < 3; i++)
      do_cycle(1'b1, 1'b1, 24'($urandom));
    frame_w = 10'd2;
    frame_h = 10'd1;
    start = 1'b1;
    do_cycle(1'b1, 1'b1, 24'($urandom));
    start = 1'b0;
    chk("busy_start_ign", 32'(busy), 32'h1);
    run_until_done(100, 100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  task automatic in_ready_dummy();
  endtask

endmodule
